tx_frame_sched: RTL and testbench
=================================

Name: tx_frame_sched

Overview:
Frame scheduler in the clk125 domain, placed between the ADC sample FIFO (40-bit words) and the RGMII tx word serializer. Two requesters share the tx path: the ADC sample stream (FIFO almost-full) and a single-word status channel. The block arbitrates between them, drives the FIFO read enable, and frames every transfer as a header word, then payload words, then an inter-frame gap. It replaces the direct FIFO-to-tx coupling.

Parameters:
PAYLOAD_WORDS, 32, 40-bit sample words per sample frame (1..255)
IFG_CYCLES, 12, idle clk125 cycles after each frame's last word is accepted (>=1)
MAX_BURST, 4, consecutive sample frames after which a pending status request is granted

Ports:
clk125  in  1  single clock, 125 MHz
reset  in  1  asynchronous, active-high reset
fifo_afull  in  1  sample FIFO almost-full
fifo_rden  out  1  sample FIFO read enable; data valid on fifo_q exactly 1 cycle later
fifo_q  in  40  sample FIFO read data
stat_req  in  1  status request; held high until stat_ack
stat_data  in  40  status payload; stable while stat_req is high
stat_ack  out  1  1-cycle pulse when the status payload word is accepted downstream
odata  out  40  word to tx serializer
ovalid  out  1  odata valid
osof  out  1  odata is a header word
oeof  out  1  odata is the last word of a frame
oready  in  1  tx serializer accepts odata this cycle
busy  out  1  state is not IDLE

Behaviour:
- Reset: state=IDLE; fifo_rden, stat_ack, ovalid, osof, oeof, busy = 0; odata=0; seq=0; burst_cnt=0; read-in-flight flag=0. Reset mid-frame aborts the frame; words already read from the FIFO are discarded.
- Transfer rule: a word moves when ovalid && oready. While ovalid && !oready, odata/osof/oeof hold stable. A single output register holds the word; there is no other buffering.
- States: IDLE, HDR, SAMP, STAT, GAP.
- IDLE arbitration, evaluated every cycle:
  - if stat_req && (!fifo_afull || burst_cnt>=MAX_BURST): grant status, go to HDR, type=0x02, len=1;
  - else if fifo_afull: grant samples, go to HDR, type=0x01, len=PAYLOAD_WORDS;
  - else remain in IDLE.
  - The header word is loaded into the output register on the same edge as the transition, so ovalid=1 in the first HDR cycle.
- Header format: [39:32]=0xA5, [31:24]=type, [23:8]=seq, [7:0]=len. osof=1 and oeof=0 on the header word. seq increments by 1 when the header is accepted and wraps 0xFFFF->0x0000. seq is shared by both frame types.
- burst_cnt: cleared when a status frame is granted. Incremented, saturating at MAX_BURST, when a sample frame is granted.
- HDR: when the header is accepted, go to SAMP (samples) or STAT (status).
- STAT: stat_data is captured into the output register when the header is accepted. oeof=1 on this word. On acceptance, stat_ack=1 for that cycle, then go to GAP.
- SAMP:
  - fifo_rden=1 when rd_cnt<PAYLOAD_WORDS && !inflight && (!ovalid || oready). This allows one read in flight and gives a maximum rate of 1 word per 2 cycles.
  - The cycle after a rden pulse, fifo_q is loaded into the output register with ovalid=1. oeof=1 when it is word number PAYLOAD_WORDS.
  - The FIFO is read only in SAMP. fifo_afull is not re-checked mid-frame; the FIFO guarantees PAYLOAD_WORDS of data at almost-full.
  - When the last word is accepted, go to GAP.
- GAP: ovalid=0 for exactly IFG_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait.
- Simultaneous stat_req and fifo_afull with burst_cnt<MAX_BURST: samples win. With burst_cnt>=MAX_BURST: status wins.
- Counters: rd_cnt and wr_cnt are 8-bit and reset at each HDR entry. The gap counter is sized to hold IFG_CYCLES.

Test Plan:
1. seq=0, fifo_afull pulsed for 1 cycle, oready=1, FIFO preloaded with 1..32 -> odata=0xA5_01_0000_20 with osof, then words 1..32 in order, oeof on word 32, exactly 32 fifo_rden pulses, ovalid low for 12 cycles, busy low afterwards.
2. fifo_afull=0, stat_req with stat_data=0x12_3456_789A, seq=1 -> header 0xA5_02_0001_01, then 0x123456789A with oeof, stat_ack high exactly in that transfer cycle.
3. fifo_afull and stat_req held high from reset -> 4 sample frames (seq 0..3), then a status frame (seq 4), then sample frames resume. stat_ack appears once.
4. Sample frame with oready randomly 50% low -> all 32 words delivered once, in order. odata/osof/oeof stable whenever ovalid && !oready. No rden while the output register is full and stalled.
5. Run 65536 status frames -> the header after seq 0xFFFF carries seq 0x0000.
6. Assert reset asynchronously after payload word 10 of a sample frame -> all outputs 0 without waiting for a clock edge. After release with afull high, the next header has seq 0x0000 and a full 32-word frame follows.

Source files
------------

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: arbitrates the ADC sample stream and a single-word status channel
// onto the tx serializer, framing each transfer as header, payload, inter-frame gap.
module tx_frame_sched #(
  parameter int PAYLOAD_WORDS = 32,
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_BURST     = 4
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        fifo_afull,
  output logic        fifo_rden,
  input  logic [39:0] fifo_q,
  input  logic        stat_req,
  input  logic [39:0] stat_data,
  output logic        stat_ack,
  output logic [39:0] odata,
  output logic        ovalid,
  output logic        osof,
  output logic        oeof,
  input  logic        oready,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [7:0]    PW8   = 8'(PAYLOAD_WORDS);
  localparam logic [GW-1:0] GLAST = GW'(IFG_CYCLES - 1);
  localparam logic [BW-1:0] BMAX  = BW'(MAX_BURST);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SAMP, S_STAT, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [39:0]   odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic          osof_q, osof_d;
  logic          oeof_q, oeof_d;
  logic [15:0]   seq_q, seq_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]    rd_cnt_q, rd_cnt_d;
  logic [7:0]    wr_cnt_q, wr_cnt_d;
  logic          inflight_q, inflight_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          is_stat_q, is_stat_d;
  logic          xfer;

  // Output handshake: a word moves on a cycle where ovalid && oready; while ovalid is
  // high and oready low, odata/osof/oeof are held. The output register is the only buffer.
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      osof_q      <= 1'b0;
      oeof_q      <= 1'b0;
      seq_q       <= '0;
      burst_cnt_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      gap_cnt_q   <= '0;
      is_stat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      osof_q      <= osof_d;
      oeof_q      <= oeof_d;
      seq_q       <= seq_d;
      burst_cnt_q <= burst_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      inflight_q  <= inflight_d;
      gap_cnt_q   <= gap_cnt_d;
      is_stat_q   <= is_stat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    odata_d     = odata_q;
    ovalid_d    = ovalid_q;
    osof_d      = osof_q;
    oeof_d      = oeof_q;
    seq_d       = seq_q;
    burst_cnt_d = burst_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    inflight_d  = inflight_q;
    gap_cnt_d   = gap_cnt_q;
    is_stat_d   = is_stat_q;
    xfer        = ovalid_q && oready;
    fifo_rden   = (state_q == S_SAMP) && (rd_cnt_q < PW8) && !inflight_q &&
                  (!ovalid_q || oready);
    stat_ack    = (state_q == S_STAT) && xfer;

    case (state_q)
      S_IDLE: begin
        // Status preempts samples only when no samples are pending or the burst quota is used.
        if (stat_req && (!fifo_afull || burst_cnt_q >= BMAX)) begin
          is_stat_d   = 1'b1;
          burst_cnt_d = '0;
          odata_d     = {8'hA5, 8'h02, seq_q, 8'd1};
        end else if (fifo_afull) begin
          is_stat_d   = 1'b0;
          if (burst_cnt_q < BMAX) burst_cnt_d = burst_cnt_q + BW'(1);
          odata_d     = {8'hA5, 8'h01, seq_q, PW8};
        end
        if (stat_req || fifo_afull) begin
          state_d  = S_HDR;
          ovalid_d = 1'b1;
          osof_d   = 1'b1;
          oeof_d   = 1'b0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          seq_d  = seq_q + 16'd1;
          osof_d = 1'b0;
          if (is_stat_q) begin
            odata_d = stat_data;
            oeof_d  = 1'b1;
            state_d = S_STAT;
          end else begin
            ovalid_d = 1'b0;
            state_d  = S_SAMP;
          end
        end
      end
      S_SAMP: begin
        if (xfer) begin
          ovalid_d = 1'b0;
          oeof_d   = 1'b0;
          if (oeof_q) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end
        if (fifo_rden) begin
          inflight_d = 1'b1;
          rd_cnt_d   = rd_cnt_q + 8'd1;
        end
        // fifo_q is valid the cycle after rden; the register is free by construction.
        if (inflight_q) begin
          inflight_d = 1'b0;
          odata_d    = fifo_q;
          ovalid_d   = 1'b1;
          oeof_d     = (wr_cnt_q + 8'd1 == PW8);
          wr_cnt_d   = wr_cnt_q + 8'd1;
        end
      end
      S_STAT: begin
        if (xfer) begin
          ovalid_d  = 1'b0;
          oeof_d    = 1'b0;
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GLAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign odata     = odata_q;
  assign ovalid    = ovalid_q;
  assign osof      = osof_q;
  assign oeof      = oeof_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: FIFO model, transfer monitor, expected-frame queue.
module tb_tx_frame_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_afull = 1'b0;
  logic        fifo_rden;
  logic [39:0] fifo_q = '0;
  logic        stat_req = 1'b0;
  logic [39:0] stat_data = '0;
  logic        stat_ack;
  logic [39:0] odata;
  logic        ovalid, osof, oeof;
  logic        oready = 1'b1;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_chk = 0;
  int n_pass = 0;

  logic [42:0] rx_q[$];
  logic [42:0] exp_q[$];
  int rden_cnt = 0;
  int ack_cnt = 0;
  int last_gap = -1;
  bit rand_ready = 1'b0;

  logic [39:0] fifo_mem [0:255];
  logic [7:0]  rd_ptr = '0;
  logic        fifo_clr = 1'b0;

  always #4 clk = ~clk;

  tx_frame_sched dut (
    .clk125(clk), .reset(reset), .fifo_afull(fifo_afull), .fifo_rden(fifo_rden),
    .fifo_q(fifo_q), .stat_req(stat_req), .stat_data(stat_data), .stat_ack(stat_ack),
    .odata(odata), .ovalid(ovalid), .osof(osof), .oeof(oeof), .oready(oready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // FIFO model: data appears on fifo_q the cycle after a read enable.
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= 8'd0;
    else if (fifo_rden) begin
      fifo_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Monitor: records transfers, checks stall stability, measures the gap after each frame.
  bit          prev_stall = 1'b0;
  logic [39:0] prev_d = '0;
  logic [1:0]  prev_f = '0;
  bit          in_gap = 1'b0;
  int          gap_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      in_gap = 1'b0;
      gap_cnt = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_data", odata, prev_d);
        chk("hold_flags", {osof, oeof}, prev_f);
      end
      if (ovalid && !oready) chk("no_rden_stall", fifo_rden, 1'b0);
      prev_stall = ovalid && !oready;
      prev_d = odata;
      prev_f = {osof, oeof};
      if (fifo_rden) rden_cnt++;
      if (stat_ack) ack_cnt++;
      if (in_gap) begin
        if (busy && !ovalid) gap_cnt++;
        else begin
          last_gap = gap_cnt;
          in_gap = 1'b0;
        end
      end
      if (ovalid && oready) begin
        rx_q.push_back({stat_ack, osof, oeof, odata});
        if (oeof) begin
          in_gap = 1'b1;
          gap_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n, input logic [39:0] first);
    fifo_clr = 1'b1;
    for (int i = 0; i < n; i++) fifo_mem[i] = first + 40'(i);
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int a;
    a = ack_cnt;
    for (int c = 0; c < budget; c++) begin
      if (rand_ready) oready = 1'($urandom_range(0, 1));
      tick();
      if (ack_cnt != a) stat_req = 1'b0;
      if (rx_q.size() >= n) break;
    end
    chk({tag, "_reached"}, rx_q.size() >= n, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200 && busy; c++) tick();
    chk({tag, "_idle"}, busy, 1'b0);
    tick();
  endtask

  task automatic add_samp_frame(input logic [15:0] seq, input logic [39:0] first);
    exp_q.push_back({3'b010, 8'hA5, 8'h01, seq, 8'd32});
    for (int i = 0; i < 32; i++) exp_q.push_back({2'b00, i == 31, first + 40'(i)});
  endtask

  task automatic add_stat_frame(input logic [15:0] seq, input logic [39:0] d);
    exp_q.push_back({3'b010, 8'hA5, 8'h02, seq, 8'd1});
    exp_q.push_back({3'b101, d});
  endtask

  task automatic cmp_frames(input string tag, input int base);
    logic [42:0] got;
    chk({tag, "_count"}, rx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : '0;
      chk({tag, "_word"}, got, exp_q[i]);
    end
    exp_q.delete();
  endtask

  int base, r0, a0;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rden", fifo_rden, 1'b0);
    chk("rst_ack", stat_ack, 1'b0);
    chk("rst_odata", odata, 40'h0);
    chk("rst_flags", {osof, oeof}, 2'b00);
    chk("rst_state", dbg_state, 3'd0);
    reset = 1'b0;
    tick();

    // Single sample frame, afull pulsed for one cycle
    load_fifo(32, 40'd1);
    base = rx_q.size();
    r0 = rden_cnt;
    fifo_afull = 1'b1;
    tick();
    fifo_afull = 1'b0;
    add_samp_frame(16'h0000, 40'd1);
    run_until(base + 33, 400, "t1");
    wait_idle("t1");
    cmp_frames("t1", base);
    chk("t1_rden", rden_cnt - r0, 32);
    chk("t1_gap", last_gap, 12);

    // Status frame
    base = rx_q.size();
    a0 = ack_cnt;
    stat_data = 40'h123456789A;
    stat_req = 1'b1;
    add_stat_frame(16'h0001, 40'h123456789A);
    run_until(base + 2, 100, "t2");
    wait_idle("t2");
    cmp_frames("t2", base);
    chk("t2_acks", ack_cnt - a0, 1);
    chk("t2_gap", last_gap, 12);

    // Both requesters held from reset: 4 sample frames, status, then samples resume
    reset = 1'b1;
    load_fifo(160, 40'd1);
    stat_data = 40'h0BADC0FFEE;
    stat_req = 1'b1;
    fifo_afull = 1'b1;
    reset = 1'b0;
    base = rx_q.size();
    a0 = ack_cnt;
    add_samp_frame(16'h0000, 40'd1);
    add_samp_frame(16'h0001, 40'd33);
    add_samp_frame(16'h0002, 40'd65);
    add_samp_frame(16'h0003, 40'd97);
    add_stat_frame(16'h0004, 40'h0BADC0FFEE);
    add_samp_frame(16'h0005, 40'd129);
    run_until(base + 167, 3000, "t3");
    fifo_afull = 1'b0;
    wait_idle("t3");
    cmp_frames("t3", base);
    chk("t3_acks", ack_cnt - a0, 1);

    // Sample frame under random backpressure
    load_fifo(32, 40'h1000);
    base = rx_q.size();
    fifo_afull = 1'b1;
    tick();
    fifo_afull = 1'b0;
    add_samp_frame(16'h0006, 40'h1000);
    rand_ready = 1'b1;
    run_until(base + 33, 1500, "t4");
    rand_ready = 1'b0;
    oready = 1'b1;
    wait_idle("t4");
    cmp_frames("t4", base);

    // Sequence wrap: preset seq to 0xFFFF while idle, then two status frames
    @(negedge clk);
    dut.seq_q = 16'hFFFF;
    tick();
    base = rx_q.size();
    stat_data = 40'hC0DE000001;
    stat_req = 1'b1;
    add_stat_frame(16'hFFFF, 40'hC0DE000001);
    run_until(base + 2, 100, "t5a");
    wait_idle("t5a");
    cmp_frames("t5a", base);
    base = rx_q.size();
    stat_data = 40'hC0DE000002;
    stat_req = 1'b1;
    add_stat_frame(16'h0000, 40'hC0DE000002);
    run_until(base + 2, 100, "t5b");
    wait_idle("t5b");
    cmp_frames("t5b", base);

    // Asynchronous reset after payload word 10, then a clean frame from seq 0
    load_fifo(32, 40'd1);
    base = rx_q.size();
    fifo_afull = 1'b1;
    tick();
    fifo_afull = 1'b0;
    run_until(base + 11, 400, "t6_pre");
    #1;
    reset = 1'b1;
    #1;
    chk("arst_ovalid", ovalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rden", fifo_rden, 1'b0);
    chk("arst_ack", stat_ack, 1'b0);
    chk("arst_odata", odata, 40'h0);
    chk("arst_flags", {osof, oeof}, 2'b00);
    tick();
    load_fifo(32, 40'h2000);
    fifo_afull = 1'b1;
    reset = 1'b0;
    base = rx_q.size();
    add_samp_frame(16'h0000, 40'h2000);
    run_until(base + 33, 400, "t6");
    fifo_afull = 1'b0;
    wait_idle("t6");
    cmp_frames("t6", base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
